// File: rtl/mem_fill_ctrl_if.sv
// Memory read port between the line-fill controller (master) and a multi-cycle memory (slave).
interface mem_fill_ctrl_if;
  logic        en;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] rdata;
  logic        valid;

  modport master (output en, wr, addr, input rdata, valid);
  modport slave  (input en, wr, addr, output rdata, valid);
endinterface

// File: rtl/mem_fill_ctrl.sv
// Cache line fill: issues back-to-back reads for one aligned line, writes returned words in order.
// Optional read watchdog enabled by defining MEM_FILL_TIMEOUT_EN.
module mem_fill_ctrl #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned MEM_LAT    = 4,
  parameter int unsigned TIMEOUT    = 32,
  localparam int unsigned IdxW      = $clog2(LINE_WORDS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                miss_req_i,
  input  logic [15:0]         miss_addr_i,
  mem_fill_ctrl_if.master     mem,
  output logic                line_we_o,
  output logic [IdxW-1:0]     line_idx_o,
  output logic [15:0]         line_data_o,
  output logic                busy_o,
  output logic                fill_done_o,
  output logic                fill_err_o
);

  localparam int unsigned     OffW     = IdxW + 1;
  localparam int unsigned     CntW     = IdxW + 1;
  localparam logic [CntW-1:0] NumWords = CntW'(LINE_WORDS);
  localparam logic [CntW-1:0] LastWord = CntW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e            state_q, state_d;
  logic [15:0]       base_q, base_d;
  logic [CntW-1:0]   issue_q, issue_d;
  logic [CntW-1:0]   recv_q, recv_d;
  logic              line_we_q, line_we_d;
  logic [IdxW-1:0]   line_idx_q, line_idx_d;
  logic [15:0]       line_data_q, line_data_d;
  logic              timeout;

`ifdef MEM_FILL_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  logic [WdW-1:0] wd_q, wd_d;

  // Counts idle cycles since FILL entry or the last returned word.
  always_comb begin
    wd_d    = '0;
    timeout = 1'b0;
    if (state_q == StFill && !mem.valid) begin
      wd_d    = wd_q + WdW'(1);
      timeout = (wd_d == WdW'(TIMEOUT));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_d     = issue_q;
    recv_d      = recv_q;
    line_we_d   = 1'b0;
    line_idx_d  = line_idx_q;
    line_data_d = line_data_q;
    unique case (state_q)
      StIdle: begin
        issue_d = '0;
        recv_d  = '0;
        if (miss_req_i) begin
          base_d  = {miss_addr_i[15:OffW], {OffW{1'b0}}};
          state_d = StFill;
        end
      end
      StFill: begin
        if (issue_q != NumWords) issue_d = issue_q + CntW'(1);
        if (mem.valid) begin
          line_we_d   = 1'b1;
          line_idx_d  = recv_q[IdxW-1:0];
          line_data_d = mem.rdata;
          recv_d      = recv_q + CntW'(1);
          if (recv_q == LastWord) state_d = StDone;
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      issue_q     <= '0;
      recv_q      <= '0;
      line_we_q   <= 1'b0;
      line_idx_q  <= '0;
      line_data_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_q     <= issue_d;
      recv_q      <= recv_d;
      line_we_q   <= line_we_d;
      line_idx_q  <= line_idx_d;
      line_data_q <= line_data_d;
    end
  end

  // Address wraps within 16 bits; the line base keeps the offset bits clear so no carry-out occurs.
  assign mem.en   = (state_q == StFill) && (issue_q != NumWords);
  assign mem.wr   = 1'b0;
  assign mem.addr = mem.en ? base_q + 16'({issue_q[IdxW-1:0], 1'b0}) : 16'h0000;

  assign line_we_o   = line_we_q;
  assign line_idx_o  = line_idx_q;
  assign line_data_o = line_data_q;
  assign busy_o      = (state_q != StIdle);
  assign fill_done_o = (state_q == StDone);
  assign fill_err_o  = timeout;

  logic unused_cfg;
  assign unused_cfg = ^{miss_addr_i[OffW-1:0], MEM_LAT, TIMEOUT};

endmodule

// File: tb/tb_mem_fill_ctrl.sv
// Bench for mem_fill_ctrl: fixed-latency memory model, output monitor, per-scenario check tasks.
module tb_mem_fill_ctrl;
  localparam int unsigned LW  = 8;
  localparam int unsigned LAT = 4;
  localparam int unsigned TO  = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_req = 1'b0;
  logic [15:0] miss_addr = 16'h0000;
  logic        line_we;
  logic [2:0]  line_idx;
  logic [15:0] line_data;
  logic        busy;
  logic        fill_done;
  logic        fill_err;

  mem_fill_ctrl_if mem_bus ();

  mem_fill_ctrl #(
    .LINE_WORDS (LW),
    .MEM_LAT    (LAT),
    .TIMEOUT    (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .miss_req_i  (miss_req),
    .miss_addr_i (miss_addr),
    .mem         (mem_bus),
    .line_we_o   (line_we),
    .line_idx_o  (line_idx),
    .line_data_o (line_data),
    .busy_o      (busy),
    .fill_done_o (fill_done),
    .fill_err_o  (fill_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [15:0] salt = 16'h0;

  // Model/monitor state (written only by the mem_model process)
  int          due_q[$];
  logic [15:0] addr_q[$];
  int          push_total = 0;
  int          stray_ack = 0;
  int          clr_ack = 0;
  logic [15:0] en_addrs[$];
  int          wr_idx[$];
  logic [15:0] wr_data[$];
  int          en_first = -1, busy_cnt = 0, busy_first = -1;
  int          done_cnt = 0, done_nowe = 0, err_cnt = 0, err_cyc = -1, err_busy = 0;
  int          last_valid_cyc = -1, wr_seen = 0;

  // Knobs (written only by the test tasks)
  int          resp_limit = 32'h7fffffff;
  int          stray_req = 0;
  int          clr_req = 0;

  function automatic logic [15:0] data_of(input logic [15:0] a);
    return (a * 16'h9e37) ^ salt;
  endfunction

  initial begin : cyc_counter
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin : mem_model
    mem_bus.valid = 1'b0;
    mem_bus.rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (clr_req != clr_ack) begin
        en_addrs.delete(); wr_idx.delete(); wr_data.delete();
        en_first = -1; busy_cnt = 0; busy_first = -1; done_cnt = 0; done_nowe = 0;
        err_cnt = 0; err_cyc = -1; err_busy = 0; last_valid_cyc = -1; wr_seen = 0;
        clr_ack = clr_req;
      end
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        mem_bus.valid = 1'b1;
        mem_bus.rdata = data_of(addr_q[0]);
        void'(due_q.pop_front());
        void'(addr_q.pop_front());
      end else if (stray_req != stray_ack) begin
        mem_bus.valid = 1'b1;
        mem_bus.rdata = 16'($urandom);
        stray_ack++;
      end else begin
        mem_bus.valid = 1'b0;
        mem_bus.rdata = 16'($urandom);
      end
      if (mem_bus.en) begin
        if (push_total < resp_limit) begin
          due_q.push_back(cyc + LAT);
          addr_q.push_back(mem_bus.addr);
        end
        push_total++;
        if (en_addrs.size() == 0) en_first = cyc;
        en_addrs.push_back(mem_bus.addr);
      end
      if (mem_bus.wr) wr_seen++;
      if (mem_bus.valid) last_valid_cyc = cyc;
      if (line_we) begin
        wr_idx.push_back(int'(line_idx));
        wr_data.push_back(line_data);
      end
      if (busy) begin
        if (busy_cnt == 0) busy_first = cyc;
        busy_cnt++;
      end
      if (fill_done) begin
        done_cnt++;
        if (!line_we) done_nowe++;
      end
      if (fill_err) begin
        err_cnt++;
        err_cyc = cyc;
        err_busy = int'(busy);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (mem_bus.en !== 1'b0) begin errors++; $display("FAIL reset mem_en: got %b expected 0", mem_bus.en); end
    checks++; if (mem_bus.wr !== 1'b0) begin errors++; $display("FAIL reset mem_wr: got %b expected 0", mem_bus.wr); end
    checks++; if (mem_bus.addr !== 16'h0) begin errors++; $display("FAIL reset mem_addr: got %h expected 0", mem_bus.addr); end
    checks++; if (line_we !== 1'b0) begin errors++; $display("FAIL reset line_we: got %b expected 0", line_we); end
    checks++; if (line_idx !== 3'd0) begin errors++; $display("FAIL reset line_idx: got %0d expected 0", line_idx); end
    checks++; if (line_data !== 16'h0) begin errors++; $display("FAIL reset line_data: got %h expected 0", line_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    checks++; if (fill_done !== 1'b0) begin errors++; $display("FAIL reset fill_done: got %b expected 0", fill_done); end
    checks++; if (fill_err !== 1'b0) begin errors++; $display("FAIL reset fill_err: got %b expected 0", fill_err); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One complete fill; an optional second miss_req is pulsed second_at cycles after the first.
  task automatic test_fill(input logic [15:0] a, input int second_at, input logic [15:0] second_addr,
                           input string tag);
    logic [15:0] base;
    int mc, k;
    bit fin;
    base = a & ~16'(2 * LW - 1);
    @(posedge clk); #1;
    clr_req++;
    miss_addr = a;
    miss_req = 1'b1;
    mc = cyc;
    k = 0;
    fin = 1'b0;
    while (!fin && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (k == second_at) begin
        miss_req = 1'b1;
        miss_addr = second_addr;
      end else begin
        miss_req = 1'b0;
        miss_addr = 16'($urandom);
      end
      if (done_cnt > 0 && k > second_at) fin = 1'b1;
    end
    miss_req = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (!fin) begin errors++; $display("FAIL %s done_wait: got no fill_done expected one within 200 cycles", tag); end
    checks++; if (en_addrs.size() != LW) begin errors++; $display("FAIL %s mem_en_count: got %0d expected %0d", tag, en_addrs.size(), LW); end
    for (int i = 0; i < en_addrs.size(); i++) begin
      checks++;
      if (en_addrs[i] !== base + 16'(2 * i)) begin
        errors++; $display("FAIL %s mem_addr[%0d]: got %h expected %h", tag, i, en_addrs[i], base + 16'(2 * i));
      end
    end
    checks++; if (en_first != mc + 1) begin errors++; $display("FAIL %s first_req_cycle: got %0d expected %0d", tag, en_first, mc + 1); end
    checks++; if (wr_idx.size() != LW) begin errors++; $display("FAIL %s line_we_count: got %0d expected %0d", tag, wr_idx.size(), LW); end
    for (int i = 0; i < wr_idx.size(); i++) begin
      checks++;
      if (wr_idx[i] != i || wr_data[i] !== data_of(base + 16'(2 * i))) begin
        errors++;
        $display("FAIL %s line_write[%0d]: got idx %0d data %h expected idx %0d data %h", tag, i,
                 wr_idx[i], wr_data[i], i, data_of(base + 16'(2 * i)));
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s fill_done_count: got %0d expected 1", tag, done_cnt); end
    checks++; if (done_nowe != 0) begin errors++; $display("FAIL %s done_with_last_we: got %0d stray expected 0", tag, done_nowe); end
    checks++; if (busy_cnt != LW + LAT + 1) begin errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", tag, busy_cnt, LW + LAT + 1); end
    checks++; if (busy_first != mc + 1) begin errors++; $display("FAIL %s busy_rise: got %0d expected %0d", tag, busy_first, mc + 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_after: got %b expected 0", tag, busy); end
    checks++; if (err_cnt != 0) begin errors++; $display("FAIL %s fill_err_count: got %0d expected 0", tag, err_cnt); end
    checks++; if (wr_seen != 0) begin errors++; $display("FAIL %s mem_wr_seen: got %0d expected 0", tag, wr_seen); end
  endtask

  task automatic test_reset_mid();
    int n, k;
    @(posedge clk); #1;
    clr_req++;
    miss_addr = 16'($urandom);
    miss_req = 1'b1;
    @(posedge clk); #1;
    miss_req = 1'b0;
    n = 0;
    k = 0;
    while (n < 3 && k < 60) begin
      @(negedge clk); #2;
      k++;
      if (mem_bus.valid) n++;
    end
    checks++; if (n < 3) begin errors++; $display("FAIL midrst valid_wait: got %0d words expected 3", n); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clr_req++;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst busy: got %b expected 0", busy); end
    checks++; if (mem_bus.en !== 1'b0) begin errors++; $display("FAIL midrst mem_en: got %b expected 0", mem_bus.en); end
    checks++; if (mem_bus.addr !== 16'h0) begin errors++; $display("FAIL midrst mem_addr: got %h expected 0", mem_bus.addr); end
    checks++; if (line_we !== 1'b0) begin errors++; $display("FAIL midrst line_we: got %b expected 0", line_we); end
    checks++; if (line_idx !== 3'd0) begin errors++; $display("FAIL midrst line_idx: got %0d expected 0", line_idx); end
    checks++; if (line_data !== 16'h0) begin errors++; $display("FAIL midrst line_data: got %h expected 0", line_data); end
    checks++; if (fill_done !== 1'b0) begin errors++; $display("FAIL midrst fill_done: got %b expected 0", fill_done); end
    repeat (12) @(negedge clk);
    #1;
    checks++; if (wr_idx.size() != 0) begin errors++; $display("FAIL midrst late_we: got %0d writes expected 0", wr_idx.size()); end
    checks++; if (busy_cnt != 0) begin errors++; $display("FAIL midrst late_busy: got %0d cycles expected 0", busy_cnt); end
    checks++; if (en_addrs.size() != 0) begin errors++; $display("FAIL midrst late_req: got %0d requests expected 0", en_addrs.size()); end
  endtask

  task automatic test_stray_valid();
    @(posedge clk); #1;
    clr_req++;
    repeat (3) begin
      stray_req++;
      @(posedge clk); #1;
    end
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (wr_idx.size() != 0) begin errors++; $display("FAIL stray line_we: got %0d writes expected 0", wr_idx.size()); end
    checks++; if (busy_cnt != 0) begin errors++; $display("FAIL stray busy: got %0d cycles expected 0", busy_cnt); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL stray fill_done: got %0d expected 0", done_cnt); end
  endtask

`ifdef MEM_FILL_TIMEOUT_EN
  task automatic test_timeout();
    int mc, k;
    resp_limit = push_total + 5;
    @(posedge clk); #1;
    clr_req++;
    miss_addr = 16'($urandom);
    miss_req = 1'b1;
    mc = cyc;
    @(posedge clk); #1;
    miss_req = 1'b0;
    k = 0;
    while (err_cnt == 0 && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (err_cnt != 1) begin errors++; $display("FAIL timeout err_count: got %0d expected 1", err_cnt); end
    checks++; if (err_cyc - last_valid_cyc != TO) begin errors++; $display("FAIL timeout err_delay: got %0d expected %0d", err_cyc - last_valid_cyc, TO); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL timeout fill_done: got %0d expected 0", done_cnt); end
    checks++; if (wr_idx.size() != 5) begin errors++; $display("FAIL timeout line_we_count: got %0d expected 5", wr_idx.size()); end
    checks++; if (err_busy != 1) begin errors++; $display("FAIL timeout busy_at_err: got %0d expected 1", err_busy); end
    checks++; if (busy_cnt != err_cyc - mc) begin errors++; $display("FAIL timeout busy_cycles: got %0d expected %0d", busy_cnt, err_cyc - mc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout busy_after: got %b expected 0", busy); end
    resp_limit = 32'h7fffffff;
  endtask
`endif

  initial begin : main
    salt = 16'($urandom);
    test_reset();
    test_fill(16'h1234, 0, 16'h0, "fill_1234");
    test_fill(16'hfffa, 0, 16'h0, "fill_fffa");
    test_fill(16'h1234, 3, 16'h2000, "miss_while_busy");
    test_fill(16'($urandom), LW + LAT + 1, 16'($urandom), "miss_at_done");
    test_fill(16'($urandom), 0, 16'h0, "back_to_back");
    for (int i = 0; i < 5; i++) test_fill(16'($urandom), 0, 16'h0, "random");
    test_reset_mid();
    test_fill(16'($urandom), 0, 16'h0, "after_midrst");
    test_stray_valid();
`ifdef MEM_FILL_TIMEOUT_EN
    test_timeout();
    test_fill(16'($urandom), 0, 16'h0, "after_timeout");
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
